// File: rtl/zmod_adc_spi_pkg.sv
// Shared constants for the AD9648 configuration-port responder: register map,
// reset values, FSM encoding and 24-bit frame field layout.
package zmod_adc_spi_pkg;

  localparam int ADDR_W  = 13;
  localparam int BYTE_W  = 8;
  localparam int INSTR_W = 16;

  localparam logic [ADDR_W-1:0] ADDR_SCRATCH  = 13'h0000;
  localparam logic [ADDR_W-1:0] ADDR_CHIPID   = 13'h0001;
  localparam logic [ADDR_W-1:0] ADDR_CHSEL    = 13'h0005;
  localparam logic [ADDR_W-1:0] ADDR_PWRMODE  = 13'h0008;
  localparam logic [ADDR_W-1:0] ADDR_TESTMODE = 13'h000D;
  localparam logic [ADDR_W-1:0] ADDR_OMODE    = 13'h0014;

  localparam logic [BYTE_W-1:0] SCRATCH_RST = 8'h18;
  localparam logic [BYTE_W-1:0] PERCH_RST   = 8'h00;

  // Frame layout: RW | W[1:0] | A[12:0] | DATA[7:0], MSB first
  localparam int FRM_W      = 24;
  localparam int FRM_RW_BIT = 23;
  localparam int FRM_W_MSB  = 22;
  localparam int FRM_W_LSB  = 21;
  localparam int FRM_A_MSB  = 20;
  localparam int FRM_A_LSB  = 8;
  localparam int FRM_D_MSB  = 7;
  localparam int FRM_D_LSB  = 0;

  localparam int INS_RW_BIT = FRM_RW_BIT - FRM_A_LSB;
  localparam int INS_W_MSB  = FRM_W_MSB - FRM_A_LSB;
  localparam int INS_W_LSB  = FRM_W_LSB - FRM_A_LSB;
  localparam int INS_A_MSB  = FRM_A_MSB - FRM_A_LSB;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INSTR,
    ST_WR,
    ST_RD,
    ST_DONE
  } spi_state_e;

  function automatic logic [BYTE_W-1:0] chan_pick(input logic [1:0] chsel,
                                                  input logic [BYTE_W-1:0] val_a,
                                                  input logic [BYTE_W-1:0] val_b);
    if (chsel[0])      return val_a;
    else if (chsel[1]) return val_b;
    else               return '0;
  endfunction

endpackage

// File: rtl/zmod_adc_spi_responder_pin_sync.sv
// Two-flop synchronizer followed by a registered rise/fall detector.
// lvl, rise and fall are mutually aligned, 3 clk after the pin changes.
module spi_pin_sync #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rstn,
  input  logic pin,
  output logic lvl,
  output logic rise,
  output logic fall
);

  logic [1:0] sync_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync_q <= {2{RST_VAL}};
      lvl    <= RST_VAL;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], pin};
      lvl    <= sync_q[1];
      rise   <= sync_q[1] & ~lvl;
      fall   <= ~sync_q[1] & lvl;
    end
  end

endmodule

// File: rtl/zmod_adc_spi_responder.sv
// AD9648 configuration-port SPI target: decodes 24-bit frames from the ZMOD ADC
// driver, holds a per-channel register file and drives SDIO during reads.
module zmod_adc_spi_responder
  import zmod_adc_spi_pkg::*;
#(
  parameter logic [7:0] CHIP_ID   = 8'h88,
  parameter logic [7:0] CHSEL_RST = 8'h03
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       i_sck,
  input  logic       i_cs,
  input  logic       i_sdio,
  output logic       o_sdio,
  output logic       o_sdio_oe,
  output logic [7:0] o8_chselect,
  output logic [7:0] o8_pwrmode_a,
  output logic [7:0] o8_pwrmode_b,
  output logic [7:0] o8_testmode_a,
  output logic [7:0] o8_testmode_b,
  output logic [7:0] o8_omode_a,
  output logic [7:0] o8_omode_b,
  output logic       o_frame_done,
  output logic       o_frame_err
);

  logic sck_rise, sck_fall, unused_sck_lvl;
  logic cs_lvl, cs_rise, cs_fall;
  logic sdio_lvl, unused_sdio_rise, unused_sdio_fall;

  // CS synchronizer resets to "asserted" so a frame already in flight when
  // reset releases never produces a falling edge and is ignored.
  spi_pin_sync #(.RST_VAL(1'b1)) u_sync_sck (
    .clk(clk), .rstn(rstn), .pin(i_sck),
    .lvl(unused_sck_lvl), .rise(sck_rise), .fall(sck_fall)
  );
  spi_pin_sync #(.RST_VAL(1'b0)) u_sync_cs (
    .clk(clk), .rstn(rstn), .pin(i_cs),
    .lvl(cs_lvl), .rise(cs_rise), .fall(cs_fall)
  );
  spi_pin_sync #(.RST_VAL(1'b0)) u_sync_sdio (
    .clk(clk), .rstn(rstn), .pin(i_sdio),
    .lvl(sdio_lvl), .rise(unused_sdio_rise), .fall(unused_sdio_fall)
  );

  spi_state_e state, state_nxt;

  logic [3:0]         bit_cnt;
  logic               got_byte;
  logic [ADDR_W-1:0]  addr;
  logic [1:0]         bytes_left;
  logic               stream;
  logic [INSTR_W-2:0] rx_sh;
  logic [BYTE_W-1:0]  tx_sh;
  logic [INSTR_W-1:0] instr_word;
  logic [BYTE_W-1:0]  wr_byte;
  logic               sck_r, sck_f;
  logic               instr_done, byte_done, last_byte, frame_end, clean_end;

  logic [7:0] scratch;
  logic [1:0] chsel;
  logic [7:0] pwr_a, pwr_b, tst_a, tst_b, om_a, om_b;

  // A CS rise masks a coincident sck edge through cs_lvl, dropping that bit.
  assign sck_r      = sck_rise & ~cs_lvl;
  assign sck_f      = sck_fall & ~cs_lvl;
  assign instr_word = {rx_sh, sdio_lvl};
  assign wr_byte    = instr_word[BYTE_W-1:0];
  assign last_byte  = ~stream & (bytes_left == 2'd1);
  assign clean_end  = (bit_cnt == 4'd0) & got_byte;

  function automatic logic [7:0] rd_mux(input logic [ADDR_W-1:0] a);
    case (a)
      ADDR_SCRATCH:  return scratch;
      ADDR_CHIPID:   return CHIP_ID;
      ADDR_CHSEL:    return {6'b0, chsel};
      ADDR_PWRMODE:  return chan_pick(chsel, pwr_a, pwr_b);
      ADDR_TESTMODE: return chan_pick(chsel, tst_a, tst_b);
      ADDR_OMODE:    return chan_pick(chsel, om_a, om_b);
      default:       return 8'h00;
    endcase
  endfunction

  always_comb begin
    state_nxt  = state;
    instr_done = 1'b0;
    byte_done  = 1'b0;
    frame_end  = 1'b0;
    if (cs_rise) begin
      state_nxt = ST_IDLE;
      frame_end = (state != ST_IDLE);
    end else begin
      case (state)
        ST_IDLE:  if (cs_fall) state_nxt = ST_INSTR;
        ST_INSTR: if (sck_r && bit_cnt == 4'd15) begin
          instr_done = 1'b1;
          state_nxt  = instr_word[INS_RW_BIT] ? ST_RD : ST_WR;
        end
        ST_WR, ST_RD: if (sck_r && bit_cnt == 4'd7) begin
          byte_done = 1'b1;
          if (last_byte) state_nxt = ST_DONE;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state        <= ST_IDLE;
      bit_cnt      <= 4'd0;
      got_byte     <= 1'b0;
      addr         <= '0;
      bytes_left   <= 2'd0;
      stream       <= 1'b0;
      o_sdio       <= 1'b0;
      o_sdio_oe    <= 1'b0;
      o_frame_done <= 1'b0;
      o_frame_err  <= 1'b0;
    end else begin
      state        <= state_nxt;
      o_frame_done <= frame_end & clean_end;
      o_frame_err  <= frame_end & ~clean_end;
      if (cs_rise) begin
        bit_cnt   <= 4'd0;
        o_sdio    <= 1'b0;
        o_sdio_oe <= 1'b0;
      end else begin
        if (state == ST_IDLE && cs_fall) begin
          bit_cnt  <= 4'd0;
          got_byte <= 1'b0;
        end
        if (sck_r && (state == ST_INSTR || state == ST_WR || state == ST_RD))
          bit_cnt <= (instr_done || byte_done) ? 4'd0 : bit_cnt + 4'd1;
        if (instr_done) begin
          addr       <= instr_word[INS_A_MSB:0];
          bytes_left <= instr_word[INS_W_MSB:INS_W_LSB] + 2'd1;
          stream     <= &instr_word[INS_W_MSB:INS_W_LSB];
        end
        if (byte_done) begin
          addr       <= addr - 13'd1;
          bytes_left <= bytes_left - 2'd1;
          got_byte   <= 1'b1;
        end
        if (state == ST_RD && sck_f) begin
          o_sdio_oe <= 1'b1;
          o_sdio    <= tx_sh[7];
        end
        if (state == ST_RD && byte_done && last_byte) o_sdio_oe <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (sck_r) rx_sh <= instr_word[INSTR_W-2:0];
    if (instr_done)                 tx_sh <= rd_mux(instr_word[INS_A_MSB:0]);
    else if (byte_done)             tx_sh <= rd_mux(addr - 13'd1);
    else if (state == ST_RD && sck_f) tx_sh <= {tx_sh[6:0], 1'b0};
  end

  // Register file: a write to chselect steers the very next byte of the frame.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      scratch <= SCRATCH_RST;
      chsel   <= CHSEL_RST[1:0];
      pwr_a   <= PERCH_RST;
      pwr_b   <= PERCH_RST;
      tst_a   <= PERCH_RST;
      tst_b   <= PERCH_RST;
      om_a    <= PERCH_RST;
      om_b    <= PERCH_RST;
    end else if (byte_done && state == ST_WR) begin
      case (addr)
        ADDR_SCRATCH: scratch <= wr_byte;
        ADDR_CHSEL:   chsel   <= wr_byte[1:0];
        ADDR_PWRMODE: begin
          if (chsel[0]) pwr_a <= wr_byte;
          if (chsel[1]) pwr_b <= wr_byte;
        end
        ADDR_TESTMODE: begin
          if (chsel[0]) tst_a <= wr_byte;
          if (chsel[1]) tst_b <= wr_byte;
        end
        ADDR_OMODE: begin
          if (chsel[0]) om_a <= wr_byte;
          if (chsel[1]) om_b <= wr_byte;
        end
        default: ;
      endcase
    end
  end

  assign o8_chselect   = {6'b0, chsel};
  assign o8_pwrmode_a  = pwr_a;
  assign o8_pwrmode_b  = pwr_b;
  assign o8_testmode_a = tst_a;
  assign o8_testmode_b = tst_b;
  assign o8_omode_a    = om_a;
  assign o8_omode_b    = om_b;

endmodule

// File: doc/zmod_adc_spi_responder.md
Name: zmod_adc_spi_responder

Overview:
- Synthesizable SPI target model of the AD9648 configuration port, on the far end of the ZMOD ADC 3-wire SPI.
- Receives the 24-bit frames the ADC driver issues (RW | W[1:0] | A[12:0] | DATA[7:0]) and holds a per-channel register file.
- Drives SDIO on reads.
- Used in simulation/loopback to close the configuration loop, and exports decoded register values for checking.

Parameters:
- CHIP_ID, 8'h88, value returned at address 0x01 (read-only).
- CHSEL_RST, 8'h03, reset value of channel-select register 0x05.

Ports:
- clk  in  1  system clock; at least 4x SPI sck frequency.
- rstn  in  1  asynchronous active-low reset.
- i_sck  in  1  SPI clock from master; idles high.
- i_cs  in  1  chip select, active low.
- i_sdio  in  1  SDIO from master.
- o_sdio  out  1  SDIO driven during the read data phase.
- o_sdio_oe  out  1  1 = responder drives SDIO.
- o8_chselect  out  8  register 0x05.
- o8_pwrmode_a / o8_pwrmode_b  out  8  register 0x08, per channel.
- o8_testmode_a / o8_testmode_b  out  8  register 0x0D, per channel.
- o8_omode_a / o8_omode_b  out  8  register 0x14, per channel.
- o_frame_done  out  1  1-clk pulse when CS rises after a clean frame.
- o_frame_err  out  1  1-clk pulse when CS rises mid-byte.

Behaviour:
- Input conditioning:
  - i_sck, i_cs and i_sdio each pass through a 2-flop synchronizer, then an edge detector.
  - Rise and fall events on sck are qualified only while the synced CS is low.
- Bit timing:
  - Master shifts MSB first and changes data while sck is low.
  - The responder samples synced SDIO on the detected sck rising edge.
  - Pin-to-event latency is 3 clk.
- FSM states:
  - IDLE: synced CS falling edge -> INSTR; the bit counter clears.
  - INSTR: shift 16 bits. At the 16th rise, latch RW, W and A[12:0]; set bytes_left = W+1, where W=11 means streaming (unbounded). RW=0 -> WR; RW=1 -> RD.
  - WR: shift 8 bits. At the 8th rise, commit the byte to A in the same clk, decrement A by 1 (wraps 0x0000 -> 0x1FFF), decrement bytes_left. If bytes_left reaches 0 -> DONE, else stay in WR.
  - RD: on entry, load the shift register with read data for A. o_sdio_oe rises on the first sck fall after the 16th rise. o_sdio presents shreg[7] and shifts on each sck fall. The byte ends at the 8th rise: decrement A, reload, continue as in WR.
  - DONE: ignore further sck edges until CS rises.
- Chip-select handling:
  - Synced CS rising edge in any state -> IDLE, o_sdio_oe=0.
  - o_frame_done pulses if the bit counter is on a byte boundary after at least 24 bits; otherwise o_frame_err pulses.
  - Bytes already committed are kept; a partial byte is discarded.
- Register map:
  - 0x00: RW scratch, reset 0x18.
  - 0x01: RO, returns CHIP_ID; writes are ignored.
  - 0x05: RW, reset CHSEL_RST; only bits [1:0] are stored, upper bits read 0.
  - 0x08, 0x0D, 0x14: per channel. A write updates channel A if chselect[0] and channel B if chselect[1]; both are updated when both bits are set. A read returns A if chselect[0], else B if chselect[1], else 0x00.
  - Reset value of all per-channel registers is 0x00.
  - Unimplemented addresses: writes are ignored, reads return 0x00.
- A write to 0x05 takes effect for the next byte in the same frame.
- Reset values of outputs: o_sdio=0, o_sdio_oe=0, pulses=0, registers as listed above, FSM=IDLE.
- rstn asserted mid-frame clears everything immediately. After deassertion the responder waits for a fresh CS falling edge, so a frame already in progress is ignored.
- An sck rise and a CS rise in the same clk: the CS rise wins and the bit is dropped.

Decomposition:
- Package zmod_adc_spi_pkg holds:
  - register address localparams (0x00, 0x01, 0x05, 0x08, 0x0D, 0x14);
  - reset values;
  - the FSM state encoding;
  - the 24-bit frame field offsets, shared with the driver bench.
- One sub-module, spi_pin_sync: 2-flop synchronizer plus rise/fall detector, instantiated for sck, cs and sdio.

Test Plan:
1. Write frame 0x05=0x03, then 0x08=0x3C -> o8_pwrmode_a=o8_pwrmode_b=0x3C; o_frame_done pulses twice; o_frame_err never asserts.
2. Write 0x05=0x01, 0x14=0x31, 0x05=0x02, 0x14=0x21 -> o8_omode_a=0x31, o8_omode_b=0x21.
3. Read 0x01 (instruction 0x8001) -> o_sdio_oe=1 for exactly the 8 data bits; master captures 0x88; writing 0x55 to 0x01 leaves the read value 0x88.
4. W=01 write at 0x0D with data 0x4F, 0xAA -> 0x0D=0x4F on the selected channels; second byte goes to 0x0C and is ignored; o_frame_done pulses.
5. CS raised after 20 bits of a write to 0x08 -> o_frame_err pulses; registers are unchanged; the next clean frame is accepted.
6. rstn pulsed low at bit 10 of a frame -> all outputs return to reset values; the remainder of that frame is ignored; a following full frame 0x0D=0x4F is applied.
